lm_sm_sequencer: RTL and testbench

- Decode-side producer for the ID-to-RR pipeline register.
- Passes ordinary instructions straight through.
- Expands each LM (load multiple) or SM (store multiple) into one LW or SW micro-op per cycle. Each micro-op carries the parent's pc, pc_next, spec_taken and cntrl.
- Holds the IF/ID register while a multi-op sequence drains. Honours downstream stall and branch flush.

---
 rtl/lm_sm_sequencer.sv | 100 ++++++++++
 tb/tb_lm_sm_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: passes ordinary instructions through and expands LM/SM into per-register LW/SW micro-ops
module lm_sm_sequencer #(
  parameter logic [3:0] LM_OPCODE = 4'b0110,
  parameter logic [3:0] SM_OPCODE = 4'b0111,
  parameter logic [3:0] LW_OPCODE = 4'b0100,
  parameter logic [3:0] SW_OPCODE = 4'b0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic [15:0] in_pc_next,
  input  logic        in_spec_taken,
  input  logic [9:0]  in_cntrl,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic [15:0] out_pc_next,
  output logic        out_spec_taken,
  output logic [9:0]  out_cntrl,
  output logic        out_last,
  output logic        hold_ifid,
  output logic        busy
);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t      state_q;
  logic [7:0]  mask_q, orig_q;
  logic [2:0]  ra_q;
  logic        lm_q, spec_q;
  logic [15:0] pc_q, pcn_q;
  logic [9:0]  cntrl_q;
  logic        seq, is_lm, mult, lm, last, kill;
  logic [2:0]  ra, idx, k;
  logic [7:0]  m, orig, m_nd;
  logic [3:0]  cnt;
  always_comb begin
    seq = state_q == SEQ;
    is_lm = in_instr[15:12] == LM_OPCODE;
    mult = in_valid && (is_lm || in_instr[15:12] == SM_OPCODE);
    lm = seq ? lm_q : is_lm;
    ra = seq ? ra_q : in_instr[11:9];
    m = seq ? mask_q : in_instr[7:0];
    orig = seq ? orig_q : in_instr[7:0];
    // LM keeps its base register for last; falls back to RA once nothing else remains
    m_nd = lm ? m & ~(8'd1 << ra) : m;
    idx = ra;
    for (int i = 7; i >= 0; i--) if (m_nd[i]) idx = 3'(i);
    cnt = '0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, m[i]};
      if (orig[i] && 3'(i) < idx) k = k + 3'd1;
    end
    last = cnt == 4'd1;
    kill = flush || rst;
    out_valid = !kill && (seq || (mult ? cnt != 4'd0 : in_valid));
    out_instr = (seq || mult) ? {lm ? LW_OPCODE : SW_OPCODE, idx, ra, 3'd0, k} : in_instr;
    out_pc = seq ? pc_q : in_pc;
    out_pc_next = seq ? pcn_q : in_pc_next;
    out_spec_taken = seq ? spec_q : in_spec_taken;
    out_cntrl = seq ? cntrl_q : in_cntrl;
    out_last = (seq || mult) ? last : 1'b1;
    hold_ifid = !kill && (seq || mult) && cnt > 4'd1;
    busy = seq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      orig_q <= '0;
      ra_q <= '0;
      lm_q <= 1'b0;
      pc_q <= '0;
      pcn_q <= '0;
      spec_q <= 1'b0;
      cntrl_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      mask_q <= '0;
    end else if (!stall) begin
      if (seq) begin
        mask_q <= m & ~(8'd1 << idx);
        if (last) state_q <= IDLE;
      end else if (mult && cnt > 4'd1) begin
        state_q <= SEQ;
        mask_q <= m & ~(8'd1 << idx);
        orig_q <= in_instr[7:0];
        ra_q <= in_instr[11:9];
        lm_q <= is_lm;
        pc_q <= in_pc;
        pcn_q <= in_pc_next;
        spec_q <= in_spec_taken;
        cntrl_q <= in_cntrl;
      end
    end
  end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: queue-based reference model with random and directed stimulus
module tb_lm_sm_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_spec_taken, stall, flush;
  logic [15:0] in_instr, in_pc, in_pc_next;
  logic [9:0] in_cntrl;
  logic out_valid, out_spec_taken, out_last, hold_ifid, busy;
  logic [15:0] out_instr, out_pc, out_pc_next;
  logic [9:0] out_cntrl;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  typedef logic [15:0] op_q_t[$];
  op_q_t pend;
  logic [15:0] p_pc, p_pcn;
  logic p_spec;
  logic [9:0] p_cntrl;

  lm_sm_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_pc_next(in_pc_next), .in_spec_taken(in_spec_taken), .in_cntrl(in_cntrl),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .out_spec_taken(out_spec_taken),
    .out_cntrl(out_cntrl), .out_last(out_last), .hold_ifid(hold_ifid), .busy(busy)
  );

  function automatic bit is_ms(input logic [15:0] ins);
    return ins[15:12] == 4'h6 || ins[15:12] == 4'h7;
  endfunction

  // Micro-op list for one LM/SM: ascending registers, LM base deferred, offset = rank in mask
  function automatic op_q_t expand(input logic [15:0] ins);
    op_q_t q;
    logic [7:0] mask = ins[7:0];
    logic [2:0] ra = ins[11:9];
    bit lm = ins[15:12] == 4'h6;
    logic [3:0] opc = lm ? 4'h4 : 4'h5;
    for (int i = 0; i < 8; i++)
      if (mask[i] && !(lm && i == int'(ra)))
        q.push_back({opc, 3'(i), ra, 6'($countones(mask & 8'((1 << i) - 1)))});
    if (lm && mask[ra]) q.push_back({opc, ra, ra, 6'($countones(mask & 8'((1 << ra) - 1)))});
    return q;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic ev, eh, el, es, full;
    logic [15:0] ei, ep, epn;
    logic [9:0] ec;
    op_q_t ops;
    full = 1;
    el = 1;
    eh = 0;
    ei = in_instr;
    ep = in_pc;
    epn = in_pc_next;
    es = in_spec_taken;
    ec = in_cntrl;
    ev = in_valid;
    if (flush || rst) begin
      ev = 0;
      full = 0;
    end else if (pend.size() != 0) begin
      ev = 1;
      ei = pend[0];
      ep = p_pc;
      epn = p_pcn;
      es = p_spec;
      ec = p_cntrl;
      el = pend.size() == 1;
      eh = !el;
    end else if (in_valid && is_ms(in_instr)) begin
      ops = expand(in_instr);
      ev = ops.size() != 0;
      full = ev;
      if (full) ei = ops[0];
      el = ops.size() == 1;
      eh = ops.size() > 1;
    end
    chk("valid", 16'(out_valid), 16'(ev));
    chk("hold", 16'(hold_ifid), 16'(eh));
    chk("busy", 16'(busy), 16'(pend.size() != 0));
    if (full) begin
      chk("instr", out_instr, ei);
      chk("pc", out_pc, ep);
      chk("pc_next", out_pc_next, epn);
      chk("spec", 16'(out_spec_taken), 16'(es));
      chk("cntrl", 16'(out_cntrl), 16'(ec));
      chk("last", 16'(out_last), 16'(el));
    end
  endtask

  task automatic model_update();
    op_q_t ops;
    if (rst || flush) pend.delete();
    else if (!stall) begin
      if (pend.size() != 0) pend.delete(0);
      else if (in_valid && is_ms(in_instr)) begin
        ops = expand(in_instr);
        if (ops.size() > 1) begin
          pend = ops;
          pend.delete(0);
          p_pc = in_pc;
          p_pcn = in_pc_next;
          p_spec = in_spec_taken;
          p_cntrl = in_cntrl;
        end
      end
    end
  endtask

  task automatic drv(input logic v, input logic [15:0] ins, input logic st, input logic fl, input logic r);
    @(posedge clk);
    model_update();
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    in_pc = 16'($urandom);
    in_pc_next = 16'($urandom);
    in_spec_taken = 1'($urandom);
    in_cntrl = 10'($urandom);
    stall = st;
    flush = fl;
    rst = r;
    #1;
    if (chk_en) model_check();
  endtask

  logic [15:0] ppc, ins;
  logic [7:0] mask;
  initial begin
    {in_valid, in_instr, in_pc, in_pc_next, in_spec_taken, in_cntrl, stall, flush} = '0;
    rst = 1;
    drv(0, 16'h0, 0, 0, 1);
    drv(0, 16'h0, 0, 0, 1);
    chk_en = 1;
    drv(1, 16'h1234, 0, 0, 0);
    chk("add_instr", out_instr, 16'h1234);
    chk("add_valid", 16'(out_valid), 16'h1);
    chk("add_last", 16'(out_last), 16'h1);
    chk("add_hold", 16'(hold_ifid), 16'h0);
    chk("add_busy", 16'(busy), 16'h0);
    drv(1, 16'h640B, 0, 0, 0);
    ppc = in_pc;
    chk("lm_op0", out_instr, 16'h4080);
    chk("lm_hold0", 16'(hold_ifid), 16'h1);
    chk("lm_last0", 16'(out_last), 16'h0);
    drv(1, 16'h640B, 0, 0, 0);
    chk("lm_op1", out_instr, 16'h4281);
    chk("lm_hold1", 16'(hold_ifid), 16'h1);
    chk("lm_pc1", out_pc, ppc);
    drv(1, 16'h640B, 0, 0, 0);
    chk("lm_op2", out_instr, 16'h4682);
    chk("lm_hold2", 16'(hold_ifid), 16'h0);
    chk("lm_last2", 16'(out_last), 16'h1);
    chk("lm_pc2", out_pc, ppc);
    drv(1, 16'h6207, 0, 0, 0);
    chk("def_op0", out_instr, 16'h4040);
    drv(1, 16'h6207, 0, 0, 0);
    chk("def_op1", out_instr, 16'h4442);
    drv(1, 16'h6207, 0, 0, 0);
    chk("def_op2", out_instr, 16'h4241);
    drv(1, 16'h7680, 0, 0, 0);
    chk("sm1_op", out_instr, 16'h5EC0);
    chk("sm1_last", 16'(out_last), 16'h1);
    chk("sm1_hold", 16'(hold_ifid), 16'h0);
    drv(1, 16'h7600, 0, 0, 0);
    chk("sm0_valid", 16'(out_valid), 16'h0);
    chk("sm0_hold", 16'(hold_ifid), 16'h0);
    drv(1, 16'h1234, 0, 0, 0);
    chk("sm1_busy", 16'(busy), 16'h0);
    drv(1, 16'h640B, 0, 0, 0);
    chk("st_op0", out_instr, 16'h4080);
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'h640B, i < 2, 0, 0);
      chk("st_op1", out_instr, 16'h4281);
    end
    drv(1, 16'h640B, 0, 0, 0);
    chk("st_op2", out_instr, 16'h4682);
    for (int j = 0; j < 2; j++) begin
      drv(1, 16'h640B, 0, 0, 0);
      chk("kill_op0", out_instr, 16'h4080);
      drv(1, 16'h640B, 0, j == 0, j == 1);
      chk("kill_valid", 16'(out_valid), 16'h0);
      chk("kill_hold", 16'(hold_ifid), 16'h0);
      drv(1, 16'h1234, 0, 0, 0);
      chk("kill_busy", 16'(busy), 16'h0);
      chk("kill_add", out_instr, 16'h1234);
      chk("kill_addv", 16'(out_valid), 16'h1);
    end
    for (int n = 0; n < 3000; n++) begin
      mask = $urandom_range(0, 3) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'h00;
      case ($urandom_range(0, 2))
        0: ins = {4'h6, 4'($urandom), mask};
        1: ins = {4'h7, 4'($urandom), mask};
        default: ins = 16'($urandom);
      endcase
      drv($urandom_range(0, 9) != 0, ins, $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
